auto_paddle: RTL and testbench
==============================

Name: auto_paddle

Overview:
- Autopilot for one paddle. It is the command-side counterpart of the button-to-position controller.
- It reads the ball's vertical position and the paddle's current position, and generates the same one-cycle up/down commands a player's buttons would.
- Its outputs drive the existing positioner's up/down inputs directly. That positioner's pos output feeds back into pos_ply.
- Used for one-player mode and attract/demo mode.

Parameters:
- PADDLE_HALF, 20, offset from paddle top (pos value) to paddle centre, in pixels.
- DEADBAND, 8, no command issued while |error| <= DEADBAND.
- REACT_TICKS, 4, ticks of reaction delay after the ball turns toward this paddle.
- HOME_Y, 280, pos value the paddle returns to while the ball moves away.
- TOP_LIM, 5, lowest legal pos value; matches the positioner's upper stop.
- BOT_LIM, 590, highest legal pos value; matches the positioner's lower stop.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = autopilot owns the paddle; 0 = idle, outputs held 0
- tick  in  1  one-cycle move strobe; at most one command is issued per tick
- ball_y  in  10  ball vertical position in pixels
- ball_toward  in  1  1 = ball travelling toward this paddle
- pos_ply  in  10  current paddle position, from the positioner
- ply_up  out  1  one-cycle "move up" command (decrements pos)
- ply_down  out  1  one-cycle "move down" command (increments pos)
- tracking  out  1  1 while the state is TRACK

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE, react_cnt = 0, ball_toward_q = 0.
  - ply_up = 0, ply_down = 0, tracking = 0.
- All outputs are registered.
- Each command is a pulse exactly one clk wide, asserted in the cycle after the tick on which it was decided.
- ply_up and ply_down are never both 1.
- Target computation, in 11-bit signed arithmetic:
  - In TRACK: target = ball_y - PADDLE_HALF, clamped to [TOP_LIM, BOT_LIM].
  - In HOME: target = HOME_Y.
  - err = target - pos_ply.
- Decision, evaluated only on tick in TRACK or HOME:
  - err > DEADBAND and pos_ply < BOT_LIM -> pulse ply_down.
  - err < -DEADBAND and pos_ply > TOP_LIM -> pulse ply_up.
  - Otherwise no pulse.
- Direction edge: ball_toward_q is ball_toward registered each cycle. A rising edge is ball_toward = 1 and ball_toward_q = 0.
- States and transitions (all synchronous):
  - IDLE: left when enable = 1. Goes to WAIT if ball_toward = 1, else to HOME.
  - WAIT: react_cnt loaded with REACT_TICKS on entry and decremented on each tick. Goes to TRACK when a tick arrives with react_cnt = 1. No pulses are issued in WAIT.
  - TRACK: pulses per the decision rule. Goes to HOME when ball_toward = 0.
  - HOME: pulses toward HOME_Y. Goes to WAIT on a rising edge of ball_toward.
  - From any state: enable = 0 -> IDLE on the next clk. Any pulse decided in that cycle is suppressed.
- REACT_TICKS = 0 means WAIT is bypassed: go directly to TRACK.
- Simultaneous events:
  - Rising edge of ball_toward while in WAIT reloads react_cnt (restart).
  - Edge coincident with tick: the state change wins and no pulse is issued that tick.
- Out-of-range input: pos_ply outside [TOP_LIM, BOT_LIM] (positioner mid-clamp) drives the paddle back in range. Up is allowed when pos_ply > BOT_LIM; down is allowed when pos_ply < TOP_LIM.
- rst_n asserted mid-pulse clears the pulse immediately (asynchronous).

Decomposition:
- Shared package (pong_pkg), shared with the positioner:
  - SCREEN_HEIGHT = 600, TOP_LIM = 5, BOT_LIM = SCREEN_HEIGHT - 10.
  - Paddle height constants.
  - State encoding IDLE / WAIT / HOME / TRACK as a localparam set.
- One sub-module, ap_react_timer: loadable down-counter advanced by tick, with a done flag. Signals: load, tick, count value, done.
- Target/error/decision logic stays inline in auto_paddle.

Test Plan:
1. Reset and idle:
   - Stimulus: rst_n low for 3 clk, then enable = 0 with 20 ticks.
   - Required: ply_up = ply_down = 0 throughout; tracking = 0.
2. Track down:
   - Stimulus: enable = 1, ball_toward = 1, ball_y = 400, pos_ply = 100, REACT_TICKS = 4.
   - Required: no pulse for the first 4 ticks, then one ply_down per tick. Bench model increments pos_ply on each ply_down; pulses stop once pos_ply >= 372.
3. Deadband and up direction:
   - Stimulus: TRACK, ball_y = 128, pos_ply = 110 (err = -2).
   - Required: no pulse.
   - Stimulus: change pos_ply to 120 (err = -12).
   - Required: ply_up pulse the cycle after the next tick.
4. Limits:
   - Stimulus: ball_y = 0, pos_ply = TOP_LIM = 5.
   - Required: no ply_up.
   - Stimulus: ball_y = 599, pos_ply = 590.
   - Required: no ply_down.
5. Home and re-engage:
   - Stimulus: drop ball_toward with pos_ply = 500.
   - Required: ply_up pulses until pos_ply <= 288; tracking = 0.
   - Stimulus: raise ball_toward coincident with a tick.
   - Required: no pulse that tick; WAIT restarts with the full 4-tick delay.
6. Abort:
   - Stimulus: enable = 0 in the same cycle as a tick during TRACK. Separately, rst_n pulse mid-command.
   - Required: no pulse after the enable drop; outputs 0 immediately on rst_n; state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong constants, state encoding and helpers (used by positioner and autopilot).
package pong_pkg;

  localparam int unsigned SCREEN_HEIGHT = 600;
  localparam int unsigned TOP_LIM       = 5;
  localparam int unsigned BOT_LIM       = SCREEN_HEIGHT - 10;

  localparam int unsigned PADDLE_HEIGHT = 40;
  localparam int unsigned PADDLE_HALF_H = PADDLE_HEIGHT / 2;

  localparam int unsigned POS_W = 10;
  localparam int unsigned ERR_W = 11;

  localparam logic signed [ERR_W-1:0] TOP_LIM_S = ERR_W'(TOP_LIM);
  localparam logic signed [ERR_W-1:0] BOT_LIM_S = ERR_W'(BOT_LIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOME  = 2'd2,
    TRACK = 2'd3
  } ap_state_e;

  // Clamp a signed position-domain value into [lo, hi].
  function automatic logic signed [ERR_W-1:0] clamp_s(
    input logic signed [ERR_W-1:0] v,
    input logic signed [ERR_W-1:0] lo,
    input logic signed [ERR_W-1:0] hi
  );
    logic signed [ERR_W-1:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/ap_react_timer.sv
// Reaction-delay timer: loadable down-counter advanced by tick, done while count == 1.
module ap_react_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  // Load has priority over a coincident tick; the counter parks at zero.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (tick && (count != '0)) begin
      count_nxt = count - W'(1);
    end
  end

  // Count register with done flag registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= (count_nxt == W'(1));
    end
  end

endmodule

// File: rtl/auto_paddle.sv
// Paddle autopilot: issues one-cycle up/down commands to chase the ball or return home.
module auto_paddle
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_HALF = 20,
  parameter int unsigned DEADBAND    = 8,
  parameter int unsigned REACT_TICKS = 4,
  parameter int unsigned HOME_Y      = 280
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tick,
  input  logic [POS_W-1:0] ball_y,
  input  logic             ball_toward,
  input  logic [POS_W-1:0] pos_ply,
  output logic             ply_up,
  output logic             ply_down,
  output logic             tracking
);

  localparam int unsigned CNT_W = 8;

  localparam logic signed [ERR_W-1:0] HALF_S  = ERR_W'(PADDLE_HALF);
  localparam logic signed [ERR_W-1:0] DB_S    = ERR_W'(DEADBAND);
  localparam logic signed [ERR_W-1:0] NDB_S   = -ERR_W'(DEADBAND);
  localparam logic signed [ERR_W-1:0] HOME_S  = ERR_W'(HOME_Y);

  // With no reaction delay, engaging goes straight to tracking.
  localparam ap_state_e ENGAGE_ST = (REACT_TICKS == 0) ? TRACK : WAIT;

  ap_state_e state;
  logic      ball_toward_q;

  logic                    rise_c;
  logic                    load_c;
  logic                    react_done;
  logic signed [ERR_W-1:0] ball_s;
  logic signed [ERR_W-1:0] pos_s;
  logic signed [ERR_W-1:0] target_c;
  logic signed [ERR_W-1:0] err_c;
  logic                    dec_up_c;
  logic                    dec_down_c;

  // Reaction-delay counter, reloaded on every engage or re-engage.
  ap_react_timer #(
    .W (CNT_W)
  ) u_react (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .tick     (tick),
    .load_val (CNT_W'(REACT_TICKS)),
    .done     (react_done)
  );

  // Target, error and move decision; out-of-range positions are always pushed back in.
  always_comb begin
    ball_s     = $signed({1'b0, ball_y});
    pos_s      = $signed({1'b0, pos_ply});
    target_c   = clamp_s(ball_s - HALF_S, TOP_LIM_S, BOT_LIM_S);
    if (state == HOME) target_c = HOME_S;
    err_c      = target_c - pos_s;
    dec_up_c   = 1'b0;
    dec_down_c = 1'b0;
    if (pos_s > BOT_LIM_S) begin
      dec_up_c = 1'b1;
    end else if (pos_s < TOP_LIM_S) begin
      dec_down_c = 1'b1;
    end else if ((err_c > DB_S) && (pos_s < BOT_LIM_S)) begin
      dec_down_c = 1'b1;
    end else if ((err_c < NDB_S) && (pos_s > TOP_LIM_S)) begin
      dec_up_c = 1'b1;
    end
  end

  // Direction edge and timer load on entry into (or restart of) the reaction wait.
  always_comb begin
    rise_c = ball_toward && !ball_toward_q;
    load_c = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE:    load_c = ball_toward;
        WAIT:    load_c = rise_c;
        HOME:    load_c = rise_c;
        default: load_c = 1'b0;
      endcase
    end
  end

  // State machine with registered one-cycle command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ball_toward_q <= 1'b0;
      ply_up        <= 1'b0;
      ply_down      <= 1'b0;
      tracking      <= 1'b0;
    end else begin
      ball_toward_q <= ball_toward;
      ply_up        <= 1'b0;
      ply_down      <= 1'b0;
      tracking      <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (ball_toward) begin
              state    <= ENGAGE_ST;
              tracking <= (ENGAGE_ST == TRACK);
            end else begin
              state <= HOME;
            end
          end
          WAIT: begin
            if (rise_c) begin
              state <= WAIT;
            end else if (tick && react_done) begin
              state    <= TRACK;
              tracking <= 1'b1;
            end
          end
          TRACK: begin
            if (!ball_toward) begin
              state <= HOME;
            end else begin
              tracking <= 1'b1;
              if (tick) begin
                ply_up   <= dec_up_c;
                ply_down <= dec_down_c;
              end
            end
          end
          HOME: begin
            if (rise_c) begin
              state    <= ENGAGE_ST;
              tracking <= (ENGAGE_ST == TRACK);
            end else if (tick) begin
              ply_up   <= dec_up_c;
              ply_down <= dec_down_c;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_paddle.sv
// Directed bench for auto_paddle with hand-computed expectations.
module tb_auto_paddle;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       ball_toward = 1'b0;
  logic [9:0] ball_y = 10'd0;
  logic [9:0] pos_ply = 10'd0;
  logic       ply_up;
  logic       ply_down;
  logic       tracking;

  int n_cmp = 0;
  int n_err = 0;

  auto_paddle dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .tick        (tick),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .pos_ply     (pos_ply),
    .ply_up      (ply_up),
    .ply_down    (ply_down),
    .tracking    (tracking)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One tick cycle, check its pulse, then a quiet cycle that must carry no pulse.
  task automatic tick_chk(input string tag, input logic exp_up, input logic exp_dn);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk({tag, "_up"}, ply_up, exp_up);
    chk({tag, "_dn"}, ply_down, exp_dn);
    clk1();
    chk({tag, "_gap"}, ply_up | ply_down, 1'b0);
  endtask

  initial begin
    logic e;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up", ply_up, 1'b0);
    chk("rst_dn", ply_down, 1'b0);
    chk("rst_trk", tracking, 1'b0);
    rst_n = 1'b1;
    ball_y = 10'd400;
    pos_ply = 10'd100;
    for (int i = 0; i < 20; i++) begin
      tick_chk("idle", 1'b0, 1'b0);
      chk("idle_trk", tracking, 1'b0);
    end

    // Track down after the 4-tick reaction delay
    enable = 1'b1;
    ball_toward = 1'b1;
    clk1();
    chk("wait_trk", tracking, 1'b0);
    for (int i = 0; i < 4; i++) tick_chk("react", 1'b0, 1'b0);
    chk("track_trk", tracking, 1'b1);
    for (int i = 0; i < 275; i++) begin
      e = (pos_ply < 10'd372);
      tick_chk("trk_dn", 1'b0, e);
      pos_ply = pos_ply + 10'(e);
    end

    // Deadband then up direction
    ball_y = 10'd128;
    pos_ply = 10'd110;
    tick_chk("deadband", 1'b0, 1'b0);
    pos_ply = 10'd120;
    tick_chk("trk_up", 1'b1, 1'b0);

    // Limits
    ball_y = 10'd0;
    pos_ply = 10'd5;
    tick_chk("top_lim", 1'b0, 1'b0);
    ball_y = 10'd599;
    pos_ply = 10'd590;
    tick_chk("bot_lim", 1'b1, 1'b0);

    // Home
    ball_toward = 1'b0;
    pos_ply = 10'd500;
    clk1();
    chk("home_trk", tracking, 1'b0);
    for (int i = 0; i < 215; i++) begin
      e = (pos_ply > 10'd288);
      tick_chk("home_up", e, 1'b0);
      chk("home_trk_lp", tracking, 1'b0);
      pos_ply = pos_ply - 10'(e);
    end

    // Re-engage on an edge coincident with a tick: no pulse, then restart in WAIT
    pos_ply = 10'd400;
    ball_toward = 1'b1;
    tick_chk("edge_tick", 1'b0, 1'b0);
    ball_y = 10'd400;
    pos_ply = 10'd100;
    tick_chk("wait_a", 1'b0, 1'b0);
    tick_chk("wait_b", 1'b0, 1'b0);
    ball_toward = 1'b0;
    clk1();
    ball_toward = 1'b1;
    clk1();
    for (int i = 0; i < 4; i++) tick_chk("restart", 1'b0, 1'b0);
    tick_chk("rearm", 1'b0, 1'b1);
    chk("rearm_trk", tracking, 1'b1);
    pos_ply = 10'd101;

    // Abort by enable drop coincident with a tick
    enable = 1'b0;
    tick_chk("abort", 1'b0, 1'b0);
    chk("abort_trk", tracking, 1'b0);
    tick_chk("abort2", 1'b0, 1'b0);
    enable = 1'b1;
    clk1();
    for (int i = 0; i < 4; i++) tick_chk("reen", 1'b0, 1'b0);

    // Asynchronous reset in the middle of a command pulse
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("pre_rst_dn", ply_down, 1'b1);
    chk("pre_rst_trk", tracking, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dn", ply_down, 1'b0);
    chk("async_up", ply_up, 1'b0);
    chk("async_trk", tracking, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clk1();
    chk("post_rst_trk", tracking, 1'b0);
    for (int i = 0; i < 4; i++) tick_chk("post_rst", 1'b0, 1'b0);
    tick_chk("post_rst_go", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
